// File: rtl/mips_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// mips_multicycle_ctrl
//
// Moore-style control FSM for a multicycle MIPS datapath (PC, IR, register
// file, ALU, unified instruction/data memory). The FSM decodes IR[31:26] in
// DECODE and drives every datapath mux select and enable from the current
// state. Memory accesses (FETCH, MEMRD, MEMWR) stall on a req/ready handshake:
// the FSM holds in the access state until mem_ready is seen high.
//
// Parameters
//   ILLEGAL_HALT  1: an unknown opcode parks the FSM in HALT until reset
//                 0: an unknown opcode is retired as a NOP (back to FETCH)
//   CNT_W         width of the performance counters (MC_PERF_CNT_EN only)
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   opcode       in   IR[31:26], stable from DECODE onward
//   mem_ready    in   memory completes the current access this cycle
//   mem_req      out  memory access request
//   memwrite     out  access is a write (only ever with mem_req)
//   iord         out  memory address select: 0 PC, 1 ALUOut
//   irwrite      out  load IR from memory data
//   pcwrite      out  unconditional PC load
//   pcwritecond  out  PC load qualified by ALU zero (beq)
//   pcsource     out  PC source: 00 ALU result, 01 ALUOut, 10 jump target
//   alusrca      out  ALU A select: 0 PC, 1 rs data
//   alusrcb      out  ALU B select: 00 rt, 01 4, 10 imm, 11 imm<<2
//   aluop        out  00 add, 01 sub, 10 funct-decoded
//   regdst       out  register file destination: 0 rt, 1 rd
//   memtoreg     out  register file write data: 0 ALUOut, 1 MDR
//   regwrite     out  register file write enable
//   halted       out  FSM is in HALT
//   state        out  current state encoding
//   cycle_cnt    out  cycles spent outside HALT  (MC_PERF_CNT_EN only)
//   instr_cnt    out  retired instructions       (MC_PERF_CNT_EN only)
//
// Configuration macro
//   MC_PERF_CNT_EN  when defined, adds the cycle_cnt / instr_cnt counters.
// -----------------------------------------------------------------------------
module mips_multicycle_ctrl #(
  parameter int ILLEGAL_HALT = 1
`ifdef MC_PERF_CNT_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       memwrite,
  output logic       iord,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       pcwritecond,
  output logic [1:0] pcsource,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       halted,
  output logic [3:0] state
`ifdef MC_PERF_CNT_EN
  , output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
`endif
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_HALT   = 4'd15
  } state_t;

  state_t cur_state;
  state_t nxt_state;

  // State register. Reset aborts any access in flight by forcing FETCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state <= S_FETCH;
    end else begin
      cur_state <= nxt_state;
    end
  end

  always_comb begin
    nxt_state   = S_FETCH;
    mem_req     = 1'b0;
    memwrite    = 1'b0;
    iord        = 1'b0;
    irwrite     = 1'b0;
    pcwrite     = 1'b0;
    pcwritecond = 1'b0;
    pcsource    = 2'b00;
    alusrca     = 1'b0;
    alusrcb     = 2'b00;
    aluop       = 2'b00;
    regdst      = 1'b0;
    memtoreg    = 1'b0;
    regwrite    = 1'b0;
    halted      = 1'b0;

    case (cur_state)
      S_FETCH: begin
        // PC+4 is computed every fetch cycle but only committed, together
        // with the IR load, on the cycle memory actually returns the word.
        // The strobes are held low while reset is asserted so a ready
        // arriving during reset cannot corrupt PC or IR.
        mem_req   = 1'b1;
        alusrcb   = 2'b01;
        irwrite   = mem_ready & rst_n;
        pcwrite   = mem_ready & rst_n;
        nxt_state = mem_ready ? S_DECODE : S_FETCH;
      end

      S_DECODE: begin
        // Branch target (PC+4 + imm<<2) is precomputed into ALUOut here.
        alusrcb = 2'b11;
        case (opcode)
          OP_RTYPE:      nxt_state = S_EXEC;
          OP_LW, OP_SW:  nxt_state = S_MEMADR;
          OP_BEQ:        nxt_state = S_BRANCH;
          OP_J:          nxt_state = S_JUMP;
          OP_ADDI:       nxt_state = S_ADDIEX;
          default:       nxt_state = (ILLEGAL_HALT != 0) ? S_HALT : S_FETCH;
        endcase
      end

      S_MEMADR: begin
        alusrca   = 1'b1;
        alusrcb   = 2'b10;
        // Only lw and sw reach this state, so anything but lw is a store.
        nxt_state = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end

      S_MEMRD: begin
        mem_req   = 1'b1;
        iord      = 1'b1;
        nxt_state = mem_ready ? S_MEMWB : S_MEMRD;
      end

      S_MEMWB: begin
        regwrite  = 1'b1;
        memtoreg  = 1'b1;
        nxt_state = S_FETCH;
      end

      S_MEMWR: begin
        mem_req   = 1'b1;
        memwrite  = 1'b1;
        iord      = 1'b1;
        nxt_state = mem_ready ? S_FETCH : S_MEMWR;
      end

      S_EXEC: begin
        alusrca   = 1'b1;
        aluop     = 2'b10;
        nxt_state = S_ALUWB;
      end

      S_ALUWB: begin
        regwrite  = 1'b1;
        regdst    = 1'b1;
        nxt_state = S_FETCH;
      end

      S_BRANCH: begin
        alusrca     = 1'b1;
        aluop       = 2'b01;
        pcwritecond = 1'b1;
        pcsource    = 2'b01;
        nxt_state   = S_FETCH;
      end

      S_JUMP: begin
        pcwrite   = 1'b1;
        pcsource  = 2'b10;
        nxt_state = S_FETCH;
      end

      S_ADDIEX: begin
        alusrca   = 1'b1;
        alusrcb   = 2'b10;
        nxt_state = S_ADDIWB;
      end

      S_ADDIWB: begin
        regwrite  = 1'b1;
        nxt_state = S_FETCH;
      end

      S_HALT: begin
        halted    = 1'b1;
        nxt_state = S_HALT;
      end

      // Encodings 12..14 are unreachable; recover through FETCH.
      default: nxt_state = S_FETCH;
    endcase
  end

  assign state = cur_state;

`ifdef MC_PERF_CNT_EN
  // Retire is any entry into FETCH from another state; both counters wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      if (cur_state != S_HALT) begin
        cycle_cnt <= cycle_cnt + CNT_W'(1);
      end
      if ((cur_state != S_FETCH) && (nxt_state == S_FETCH)) begin
        instr_cnt <= instr_cnt + CNT_W'(1);
      end
    end
  end
`endif

endmodule
